// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell fed LSB-first through a registered
// carry loop, with start/busy/done handshaking around an IDLE/RUN/DONE sequencer.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_sum;
  logic               fa_cout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        // The last bit goes straight into the visible result so sum/cout move only here.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 (directed + random) and WIDTH=13 (random).

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, sum13;

  int n_checks = 0;
  int n_fail   = 0;
  int accepted8 = 0, accepted13 = 0;
  int done_cnt8 = 0, done_cnt13 = 0;

  logic [8:0]  q8[$];
  logic [13:0] q13[$];
  logic [8:0]  last_res8  = '0;
  logic [13:0] last_res13 = '0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation and compares.
  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      check("busy_done_excl8", busy8, 1'b0);
      if (q8.size() == 0) check("unexpected_done8", 1'b1, 1'b0);
      else check("result8", {cout8, sum8}, q8.pop_front());
    end
    if (done13) begin
      done_cnt13++;
      check("busy_done_excl13", busy13, 1'b0);
      if (q13.size() == 0) check("unexpected_done13", 1'b1, 1'b0);
      else check("result13", {cout13, sum13}, q13.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int busy_cyc = 0;
    int done_cyc = 0;
    bit held_ok = 1'b1;
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    q8.push_back(exp);
    accepted8++;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (done8) begin
        done_cyc = cyc;
        break;
      end
      if (busy8) busy_cyc++;
      if ({cout8, sum8} !== last_res8) held_ok = 1'b0;
      @(negedge clk);
    end
    check("latency8", done_cyc, 9);
    check("busy_cycles8", busy_cyc, 8);
    check("hold_during_run8", held_ok, 1'b1);
    last_res8 = exp;
  endtask

  task automatic run13(input logic [12:0] a, input logic [12:0] b, input logic c);
    int done_cyc = 0;
    bit held_ok = 1'b1;
    logic [13:0] exp;
    exp = 14'(a) + 14'(b) + 14'(c);
    start13 = 1'b1; a13 = a; b13 = b; cin13 = c;
    q13.push_back(exp);
    accepted13++;
    @(negedge clk);
    start13 = 1'b0; a13 = ~a; b13 = ~b;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done13) begin
        done_cyc = cyc;
        break;
      end
      if (!busy13 || {cout13, sum13} !== last_res13) held_ok = 1'b0;
      @(negedge clk);
    end
    check("latency13", done_cyc, 14);
    check("hold_during_run13", held_ok, 1'b1);
    last_res13 = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  c;
    bit  seen;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset8", {busy8, done8, cout8, sum8}, '0);
    check("reset13", {busy13, done13, cout13, sum13}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operations, including full-carry cases.
    run8(8'h00, 8'h00, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1);
    @(negedge clk);
    check("done_one_cycle8", {busy8, done8}, 2'b00);

    // start held high: back-to-back operations every 9 cycles.
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q8.push_back(9'h046);
      accepted8++;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!done8 && c < 14);
      check("b2b_period8", c, 9);
      if (k == 2) start8 = 1'b0;
    end
    last_res8 = 9'h046;
    @(negedge clk);
    check("b2b_idle_after8", {busy8, done8}, 2'b00);

    // start pulse mid-RUN must be ignored.
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    q8.push_back(9'h010);
    accepted8++;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    c = 0;
    while (!done8 && c < 14) begin
      @(negedge clk);
      c++;
    end
    check("midrun_done_seen8", done8, 1'b1);
    last_res8 = 9'h010;
    @(negedge clk);
    check("midrun_no_restart8", {busy8, done8}, 2'b00);

    // Reset on cycle 4 of RUN aborts with no done.
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy8", busy8, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state8", {busy8, done8, cout8, sum8}, '0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    check("abort_no_done8", seen, 1'b0);
    last_res8  = '0;
    last_res13 = '0;
    run8(8'h80, 8'h80, 1'b1);
    @(negedge clk);

    // Random sweep on both widths concurrently.
    fork
      begin
        repeat (1000) run8(8'($urandom), 8'($urandom), 1'($urandom));
      end
      begin
        repeat (1000) run13(13'($urandom), 13'($urandom), 1'($urandom));
      end
    join
    repeat (3) @(negedge clk);

    check("done_count8", done_cnt8, accepted8);
    check("done_count13", done_cnt13, accepted13);
    check("queue_empty8", q8.size(), 0);
    check("queue_empty13", q13.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder sequencer built around a single instance of the team's 1-bit full_adder cell. It accepts two WIDTH-bit operands plus carry-in on a start pulse and feeds the full adder one bit per clock, LSB first, through a registered carry loop. It returns a WIDTH-bit sum and carry-out with a done pulse. It is the area-minimal alternative to a ripple-carry adder for non-latency-critical paths.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..64.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
start  input  1  request to begin an addition; sampled only in IDLE or DONE.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
cin  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while an addition is in progress (RUN state).
done  output  1  one-cycle pulse; result valid and updated.
sum  output  WIDTH  result of the last completed addition.
cout  output  1  carry-out of the last completed addition.

Behaviour:
- Interface: one clock (clk); synchronous active-low reset (rst_n).
- Datapath: one full_adder instance (a, b, cin, sum, cout ports).
  - Inputs: bit 0 of operand shift register A, bit 0 of operand shift register B, and the carry flop.
  - No other adder logic is permitted.
- Internal state:
  - A/B shift registers, WIDTH bits each.
  - Result shift register, WIDTH bits.
  - Carry flop.
  - Bit counter, $clog2(WIDTH) bits.
  - FSM.
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (rst_n=0 at an edge):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Counter, shift registers and carry flop all cleared.
  - Reset wins over every other condition, including mid-RUN. An aborted operation produces no done and leaves sum/cout at 0.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0: load A<=a, B<=b, carry<=cin, counter<=0; go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1, done=0): at each edge:
  - Shift the full_adder sum bit into the result register MSB side, shifting right.
  - carry <= full_adder cout.
  - Shift A and B right by one.
  - counter <= counter+1.
  - When counter==WIDTH-1 at the edge (last bit):
    - sum output <= completed result word, including the final bit.
    - cout output <= final carry.
    - Go to DONE.
- DONE:
  - busy=0, done=1 for exactly this cycle.
  - start=1 at the leaving edge is accepted exactly as in IDLE (back-to-back operations, go directly to RUN).
  - Otherwise go to IDLE.
- Latency: with start accepted at edge E0, bit i is processed at edge E(i+1).
  - busy is high for exactly WIDTH cycles.
  - done is high in the cycle after edge E(WIDTH).
  - Throughput is one addition per WIDTH+1 cycles.
- start while in RUN is ignored, with no effect on the operation in progress. Operand changes during RUN are ignored.
- sum/cout hold the last completed result and do not change during RUN. They update only on the completion edge.
- Arithmetic: {cout,sum} = a + b + cin, exact modulo 2^(WIDTH+1). No overflow flag.
- done and busy are never high simultaneously.

Test Plan:
- Reset, then a=8'h00, b=8'h00, cin=0, start pulse -> busy high 8 cycles; done pulse on cycle 9; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. During RUN, sum still shows the prior result.
- start held high continuously with a=8'h12, b=8'h34, cin=0 -> each op returns sum=8'h46. Back-to-back ops, with done every 9th cycle and no IDLE gap.
- Mid-RUN start pulse with a=8'hFF, b=8'hFF -> ignored; in-flight 8'h0F+8'h01 completes as sum=8'h10, cout=0.
- rst_n=0 on cycle 4 of RUN -> next cycle: busy=0, done=0, sum=0, cout=0. No done pulse follows. A new start afterwards completes correctly.
- Random sweep: 1000 random a/b/cin operations with WIDTH=8 and WIDTH=13 -> {cout,sum} == a+b+cin each time. done count equals accepted-start count.
